// File: rtl/trace_capture.sv
// Retire-stream discontinuity capture feeding the trace line FIFO.
// Ports: hart_* retire in, cfg_* control, fifo_full in; wr_en + line out,
// cap_state / entry_cnt / drop_cnt status. Option: TRACE_CAPTURE_RVC_EN.
module trace_capture #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             hart_vld,
  input  logic [31:0]      hart_pc,
  input  logic [31:0]      hart_code,
  input  logic [31:0]      hart_ra,
  input  logic [31:0]      hart_sp,
  input  logic [31:0]      hart_a0,
  input  logic [31:0]      hart_t0,
  input  logic             cfg_en,
  input  logic             cfg_clr,
  input  logic [31:0]      cfg_lo,
  input  logic [31:0]      cfg_hi,
  input  logic [CNT_W-1:0] cfg_limit,
  input  logic             fifo_full,
  output logic             wr_en,
  output logic [31:0]      index_o,
  output logic [31:0]      pc_o,
  output logic [31:0]      code_o,
  output logic [31:0]      ra_o,
  output logic [31:0]      sp_o,
  output logic [31:0]      a0_o,
  output logic [31:0]      t0_o,
  output logic [1:0]       cap_state,
  output logic [CNT_W-1:0] entry_cnt,
  output logic [CNT_W-1:0] drop_cnt
);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    ARMED   = 2'b01,
    STOPPED = 2'b10,
    BAD     = 2'b11
  } state_e;

  state_e           state_q, state_d;
  logic             first_q, first_d;
  logic [31:0]      last_pc_q, last_pc_d;
  logic [31:0]      idx_cnt_q, idx_cnt_d;
  logic             wr_en_q, wr_en_d;
  logic [31:0]      index_q, index_d;
  logic [31:0]      pc_q, pc_d;
  logic [31:0]      code_q, code_d;
  logic [31:0]      ra_q, ra_d;
  logic [31:0]      sp_q, sp_d;
  logic [31:0]      a0_q, a0_d;
  logic [31:0]      t0_q, t0_d;
  logic [CNT_W-1:0] entry_q, entry_d;
  logic [CNT_W-1:0] drop_q, drop_d;

  logic             seq;
  logic             in_win;
  logic             evt;
  logic             wr_ok;
  logic             lim_hit;
  logic [CNT_W-1:0] entry_inc;

`ifdef TRACE_CAPTURE_RVC_EN
  assign seq = (hart_pc == last_pc_q + 32'd4)
             || (hart_pc == last_pc_q + 32'd2);
`else
  assign seq = (hart_pc == last_pc_q + 32'd4);
`endif

  // lo > hi turns the window off
  assign in_win = (cfg_lo > cfg_hi)
               || ((hart_pc >= cfg_lo) && (hart_pc <= cfg_hi));

  // clear wins over any event in the same cycle
  assign evt = (state_q == ARMED) && hart_vld && !cfg_clr
            && (first_q || !seq) && in_win;
  assign wr_ok = evt && !fifo_full;

  assign entry_inc = entry_q + {{(CNT_W-1){1'b0}}, 1'b1};
  assign lim_hit = wr_ok && (cfg_limit != '0)
                && (entry_inc == cfg_limit);

  always_comb begin
    state_d   = state_q;
    first_d   = first_q;
    last_pc_d = hart_vld ? hart_pc : last_pc_q;
    idx_cnt_d = idx_cnt_q;
    wr_en_d   = 1'b0;
    index_d   = index_q;
    pc_d      = pc_q;
    code_d    = code_q;
    ra_d      = ra_q;
    sp_d      = sp_q;
    a0_d      = a0_q;
    t0_d      = t0_q;
    entry_d   = entry_q;
    drop_d    = drop_q;

    if ((state_q == ARMED) && hart_vld) begin
      first_d = 1'b0;
    end

    if (evt) begin
      idx_cnt_d = idx_cnt_q + 32'd1;
      if (wr_ok) begin
        wr_en_d = 1'b1;
        index_d = idx_cnt_q;
        pc_d    = hart_pc;
        code_d  = hart_code;
        ra_d    = hart_ra;
        sp_d    = hart_sp;
        a0_d    = hart_a0;
        t0_d    = hart_t0;
        entry_d = entry_inc;
      end else if (drop_q != '1) begin
        drop_d = drop_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end

    unique case (state_q)
      IDLE: begin
        if (cfg_en) begin
          state_d = ARMED;
          first_d = 1'b1;
        end
      end
      ARMED: begin
        if (!cfg_en) begin
          state_d = IDLE;
        end else if (lim_hit) begin
          state_d = STOPPED;
        end
      end
      STOPPED: begin
        if (!cfg_en) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (cfg_clr) begin
      state_d   = IDLE;
      first_d   = 1'b0;
      idx_cnt_d = '0;
      index_d   = '0;
      entry_d   = '0;
      drop_d    = '0;
      wr_en_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      first_q   <= 1'b0;
      last_pc_q <= '0;
      idx_cnt_q <= '0;
      wr_en_q   <= 1'b0;
      index_q   <= '0;
      pc_q      <= '0;
      code_q    <= '0;
      ra_q      <= '0;
      sp_q      <= '0;
      a0_q      <= '0;
      t0_q      <= '0;
      entry_q   <= '0;
      drop_q    <= '0;
    end else begin
      state_q   <= state_d;
      first_q   <= first_d;
      last_pc_q <= last_pc_d;
      idx_cnt_q <= idx_cnt_d;
      wr_en_q   <= wr_en_d;
      index_q   <= index_d;
      pc_q      <= pc_d;
      code_q    <= code_d;
      ra_q      <= ra_d;
      sp_q      <= sp_d;
      a0_q      <= a0_d;
      t0_q      <= t0_d;
      entry_q   <= entry_d;
      drop_q    <= drop_d;
    end
  end

  assign wr_en     = wr_en_q;
  assign index_o   = index_q;
  assign pc_o      = pc_q;
  assign code_o    = code_q;
  assign ra_o      = ra_q;
  assign sp_o      = sp_q;
  assign a0_o      = a0_q;
  assign t0_o      = t0_q;
  assign cap_state = state_q;
  assign entry_cnt = entry_q;
  assign drop_cnt  = drop_q;

endmodule

// File: doc/trace_capture.md
# trace_capture

Upstream capture stage for the on-chip simple trace. It watches the hart's retired-instruction stream and detects control-flow discontinuities, meaning a retired PC that is not the sequential successor of the previous one. Each qualifying event is registered as one trace line (index plus pc/code/ra/sp/a0/t0 snapshot) with a single-cycle write strobe into the trace line FIFO. Capture is gated by an arm/stop state machine, an optional PC address window and an entry limit; FIFO-full drops are counted.

## Interface
Parameters:
- CNT_W, 16, width of the entry-limit, entry-count and drop-count fields.

Ports:
- clk  input  1  core clock; one clock domain only.
- rst_n  input  1  asynchronous, active-low reset.
- hart_vld  input  1  retire strobe; the hart_* inputs are valid in this cycle.
- hart_pc  input  32  PC of the retired instruction.
- hart_code / hart_ra / hart_sp / hart_a0 / hart_t0  input  32 each  instruction word and register values at retire.
- cfg_en  input  1  level; 1 arms capture, 0 returns to IDLE.
- cfg_clr  input  1  single-cycle pulse; clears counters and state.
- cfg_lo / cfg_hi  input  32 each  inclusive PC window; the window is disabled when cfg_lo > cfg_hi.
- cfg_limit  input  CNT_W  number of entries to write before stopping; 0 means unlimited.
- fifo_full  input  1  trace FIFO full flag.
- wr_en  output  1  one-cycle write strobe to the trace FIFO.
- index_o  output  32  event index of the current line.
- pc_o / code_o / ra_o / sp_o / a0_o / t0_o  output  32 each  snapshot of the current line.
- cap_state  output  2  00 IDLE, 01 ARMED, 10 STOPPED.
- entry_cnt  output  CNT_W  entries written since the last clear.
- drop_cnt  output  CNT_W  events lost to fifo_full; saturates at all-ones.

## Operation
- last_pc register: loaded with hart_pc on every hart_vld cycle, in every state.
- Sequential test: hart_pc == last_pc + 4, computed mod 2^32, so 0xFFFF_FFFC followed by 0x0000_0000 counts as sequential.
- first flag: set on entry to ARMED. The first retire seen while ARMED is always treated as a discontinuity. The flag clears on that retire.
- Event: state ARMED, hart_vld = 1, (first flag set or the retire is non-sequential), and the PC is in the window (cfg_lo <= hart_pc <= cfg_hi, unsigned) or the window is disabled.
- Event with fifo_full = 0: register the line, assert wr_en next cycle, increment entry_cnt.
- Event with fifo_full = 1: no write; drop_cnt increments (saturating).
- index counter: increments on every event, written or dropped, so drops show as index gaps. The first event after a clear gets index 0.
- FSM transitions:
  - IDLE -> ARMED when cfg_en = 1.
  - ARMED -> IDLE when cfg_en = 0.
  - ARMED -> STOPPED on the edge where entry_cnt reaches a nonzero cfg_limit.
  - STOPPED -> IDLE when cfg_en = 0.
  - Encoding 11 is illegal and recovers to IDLE.
- cfg_clr has priority over all other inputs: index, entry_cnt, drop_cnt and wr_en go to 0, state goes to IDLE, and any event in that cycle is ignored. The snapshot outputs keep their values.
- Outputs are registered. Snapshot and index_o hold until the next written event.

## Timing
- Reset values: wr_en 0, index_o 0, all snapshot outputs 0, cap_state 00, entry_cnt 0, drop_cnt 0, last_pc 0, first flag 0.
- Latency: an event in cycle N gives wr_en = 1 in cycle N+1, with index_o and snapshot valid in the same cycle.
- Back-to-back events produce one wr_en per cycle with no bubbles.
- fifo_full is sampled in the event cycle only; there is no retry or buffering.
- State changes on cfg_en take effect at the next edge. A retire in the same cycle that cfg_en rises is not captured.
- Limit: the write that reaches cfg_limit is still emitted. cap_state reads 10 in the same cycle that this wr_en is high.
- Reset asserted mid-capture: all registers return to reset values asynchronously, and a pending wr_en is lost.

## Configuration
- TRACE_CAPTURE_RVC_EN defined: hart_pc == last_pc + 2 is also treated as sequential, for compressed instructions.
- Not defined: only +4 is sequential, so a +2 step is captured as an event.

## Test plan
- Arm with the window disabled and limit 0; retire 0x100, 0x104, 0x200 -> two writes: index 0 with pc 0x100, then index 1 with pc 0x200, each wr_en one cycle after its retire.
- Window lo = 0x1000, hi = 0x1FFF; jumps to 0x0800 then 0x1800 -> exactly one write, pc 0x1800, index 0.
- fifo_full = 1 during the second of three jumps -> two writes with index 0 and 2, drop_cnt = 1, entry_cnt = 2.
- Limit 2 with four jumps -> two writes, cap_state = 10 together with the second wr_en, no further writes; dropping cfg_en gives cap_state = 00.
- Retire 0xFFFF_FFFC then 0x0000_0000 -> no event; with the RVC macro, 0x100 then 0x102 -> no event, and without it -> one write.
- cfg_clr pulsed in the same cycle as an event -> no wr_en, counters 0, cap_state 00; rst_n pulsed mid-stream -> all outputs return to reset values.
